io_uart_tx_port: RTL and testbench
==================================

// Module: io_uart_tx_port
// PURPOSE
// - CPU I/O-port peripheral: answers my_cpu OUTPUT writes and INPUT reads on the io_output/io_input bus.
// - Queues bytes in a small FIFO and serialises them as 8N1 UART frames on tx.
// - Sits beside my_cpu on the same clk.
// - It is the responder end of the CPU I/O interface.
// PARAMETERS
// BASE_ID       8'h10  port id of DATA/STATUS; BASE_ID+1 is CONTROL
// CLKS_PER_BIT  16     clk cycles per UART bit, >=2
// FIFO_DEPTH    8      TX FIFO entries, one of 2/4/8
// PORTS
// clk           in   1  single clock, all state on rising edge
// rst           in   1  synchronous, active-high reset
// io_output     in   8  write data from CPU OUTPUT
// io_output_id  in   8  write port id
// io_wr_stb     in   1  1-cycle strobe, CPU OUTPUT execute cycle
// io_input_id   in   8  read port id
// io_rd_stb     in   1  1-cycle strobe, CPU INPUT execute cycle
// io_input      out  8  read data to CPU, combinational from io_input_id
// tx            out  1  UART serial out, idle high
// BEHAVIOUR
// - Reset: tx=1; state=IDLE; FIFO empty; tx_en=0; overflow=0.
//   io_input follows the read mux, so it reads STATUS=8'h01 when io_input_id==BASE_ID.
// - Write BASE_ID: push io_output into FIFO.
//   Push while full (even with a pop the same cycle) is dropped and sets overflow.
// - Write BASE_ID+1 (CONTROL):
//   - bit0 -> tx_en.
//   - bit1=1 flushes FIFO (self-clearing); flush beats a same-cycle push, which is dropped without overflow.
// - Read mux:
//   - BASE_ID -> {count[3:0], overflow, busy, full, empty}.
//   - BASE_ID+1 -> {7'b0, tx_en}.
//   - any other id -> 8'h00.
// - io_rd_stb with io_input_id==BASE_ID clears overflow after the read.
//   A same-cycle new overflow wins (stays 1).
// - FSM IDLE -> START -> DATA -> STOP:
//   - IDLE: if tx_en and FIFO non-empty, pop into shift reg, go START. tx=1.
//   - START: tx=0 for CLKS_PER_BIT cycles.
//   - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; 3-bit bit index.
//   - STOP: tx=1 for CLKS_PER_BIT cycles.
//   - End of STOP: if tx_en and non-empty, pop and go straight to START (no idle gap); else go IDLE.
// - Baud counter loads CLKS_PER_BIT-1 on state entry and counts down to 0, then advances.
// - Latency: write strobe sampled at edge N (FIFO empty, IDLE, tx_en=1) -> tx falls at edge N+1's pop, visible after edge N+2.
// - Frame length is exactly 10*CLKS_PER_BIT cycles.
// - busy = (state!=IDLE).
// - Clearing tx_en mid-frame finishes the current frame, then holds IDLE.
// - Flush mid-frame does not abort the frame in the shift reg.
// - count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
// - Simultaneous push and pop when not full: both happen, count unchanged.
// - rst mid-frame: tx=1 on the next cycle; all state returns to reset values.
// STRUCTURE
// - Shared include my_cpu_defs.vh holds:
//   - register offsets (REG_DATA=0, REG_CTRL=1);
//   - STATUS/CONTROL bit positions;
//   - FSM encodings (2-bit IDLE=0, START=1, DATA=2, STOP=3).
// - Sub-module io_tx_fifo: synchronous FIFO with push/pop/flush/full/empty/count.
// - Top holds register decode, read mux, FSM, baud counter and shift reg.
// TESTING
// - Reset, then read BASE_ID: io_input=8'h01 and tx=1 held through 100 cycles.
// - tx_en=1, write 8'hA5 with CLKS_PER_BIT=16: tx low 16 cycles, then bits 1,0,1,0,0,1,0,1 (16 cycles each), then high 16; total 160 cycles.
// - Write 3 bytes back-to-back: 3 contiguous frames (480 cycles), no idle gap; STATUS count goes 3->2->1->0.
// - tx_en=0, write 9 bytes: STATUS=8'h8A (count 8, overflow, full); read STATUS again gives 8'h82.
// - Flush while a frame is active: current frame completes; STATUS=8'h05 during the frame (busy, empty), 8'h01 after.
// - Assert rst mid-DATA: tx=1 on the next cycle; STATUS=8'h01; the next write produces a clean frame.

Source files
------------

// File: rtl/io_uart_tx_port_pkg.sv
// Shared constants for the CPU-facing UART transmit port: register offsets,
// STATUS/CONTROL bit positions and transmitter state encoding.
package io_uart_tx_port_pkg;

  localparam logic [7:0] REG_DATA = 8'd0;
  localparam logic [7:0] REG_CTRL = 8'd1;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  localparam int CTRL_TXEN  = 0;
  localparam int CTRL_FLUSH = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/io_tx_fifo.sv
// Small synchronous FIFO with flush; a push while full is dropped and a flush
// overrides any same-cycle push or pop.
module io_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DW-1:0]            din_i,
  output logic [DW-1:0]            dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_q == AW'(gi))) mem_q[gi] <= din_i;
    end
  end

endmodule

// File: rtl/io_uart_tx_port.sv
// CPU I/O-port responder: DATA/STATUS and CONTROL registers in front of a TX
// FIFO feeding an 8N1 UART serialiser.
module io_uart_tx_port
  import io_uart_tx_port_pkg::*;
#(
  parameter logic [7:0] BASE_ID      = 8'h10,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] io_output,
  input  logic [7:0] io_output_id,
  input  logic       io_wr_stb,
  input  logic [7:0] io_input_id,
  input  logic       io_rd_stb,
  output logic [7:0] io_input,
  output logic       tx
);

  localparam logic [7:0] DATA_ID = BASE_ID + REG_DATA;
  localparam logic [7:0] CTRL_ID = BASE_ID + REG_CTRL;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          txen_q, ovf_q;

  logic          wr_data, wr_ctrl, flush, rd_status, ovf_set, pop, tick;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [7:0]    status;

  assign wr_data   = io_wr_stb && (io_output_id == DATA_ID);
  assign wr_ctrl   = io_wr_stb && (io_output_id == CTRL_ID);
  assign flush     = wr_ctrl && io_output[CTRL_FLUSH];
  assign rd_status = io_rd_stb && (io_input_id == DATA_ID);
  assign ovf_set   = wr_data && fifo_full;
  assign tick      = (baud_q == '0);
  assign tx        = tx_q;

  io_tx_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_data),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (io_output),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status = '0;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_BUSY]  = (state_q != ST_IDLE);
    status[STAT_OVF]   = ovf_q;
    status[STAT_CNT_LSB +: 4] = 4'(fifo_count);
    if (io_input_id == DATA_ID)      io_input = status;
    else if (io_input_id == CTRL_ID) io_input = {7'b0, txen_q};
    else                             io_input = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= BAUD_LOAD;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      txen_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      if (wr_ctrl) txen_q <= io_output[CTRL_TXEN];
      // A new overflow in the same cycle as the STATUS read survives the clear.
      ovf_q <= rd_status ? ovf_set : (ovf_q | ovf_set);
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (txen_q && !fifo_empty) begin
          state_d = ST_START;
          pop     = 1'b1;
        end
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP: begin
        if (tick) begin
          if (txen_q && !fifo_empty) begin
            state_d = ST_START;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    baud_d    = (state_q == ST_IDLE || tick) ? BAUD_LOAD : baud_q - 1'b1;
    bit_idx_d = (state_q == ST_DATA) ? (tick ? bit_idx_q + 3'd1 : bit_idx_q) : 3'd0;
    shift_d   = shift_q;
    if (pop) shift_d = fifo_dout;
    else if (state_q == ST_DATA && tick) shift_d = {1'b0, shift_q[7:1]};
  end

  // tx is registered, so the line lags the state register by one cycle.
  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_io_uart_tx_port.sv
// Bench for io_uart_tx_port: register vectors, hand-written frame sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_io_uart_tx_port;

  localparam int C = 16;
  localparam int D = 8;
  localparam logic [7:0] BASE = 8'h10;
  localparam logic [7:0] CTRL = 8'h11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] io_output = '0, io_output_id = '0, io_input_id = '0;
  logic       io_wr_stb = 1'b0, io_rd_stb = 1'b0;
  logic [7:0] io_input;
  logic       tx;

  int errors = 0;
  int checks = 0;

  io_uart_tx_port #(.BASE_ID(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .io_output    (io_output),
    .io_output_id (io_output_id),
    .io_wr_stb    (io_wr_stb),
    .io_input_id  (io_input_id),
    .io_rd_stb    (io_rd_stb),
    .io_input     (io_input),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus position within the current frame (-1 = idle).
  logic [7:0] q[$];
  logic       m_txen, m_ovf, m_tx;
  int         pos;
  logic [7:0] cur;

  function automatic logic txval(int p, logic [7:0] b);
    if (p < 0)      return 1'b1;
    if (p < C)      return 1'b0;
    if (p < 9 * C)  return b[(p - C) / C];
    return 1'b1;
  endfunction

  function automatic logic [7:0] model_read(logic [7:0] rid);
    if (rid == BASE)
      return {4'(q.size()), m_ovf, pos >= 0, q.size() == D, q.size() == 0};
    if (rid == CTRL) return {7'b0, m_txen};
    return 8'h00;
  endfunction

  task automatic model_reset();
    q.delete();
    m_txen = 1'b0; m_ovf = 1'b0; m_tx = 1'b1; pos = -1; cur = '0;
  endtask

  task automatic model_edge(logic r, logic w, logic [7:0] wid, logic [7:0] wd,
                            logic rd, logic [7:0] rid);
    int  old_cnt;
    logic old_txen, ovf_set;
    if (r) begin
      model_reset();
      return;
    end
    m_tx     = txval(pos, cur);
    old_cnt  = q.size();
    old_txen = m_txen;
    if (pos < 0 || pos == 10 * C - 1) begin
      if (old_txen && old_cnt > 0) begin
        cur = q.pop_front();
        pos = 0;
      end else begin
        pos = -1;
      end
    end else begin
      pos++;
    end
    ovf_set = 1'b0;
    if (w && wid == BASE) begin
      if (old_cnt == D) ovf_set = 1'b1;
      else q.push_back(wd);
    end
    if (w && wid == CTRL) begin
      m_txen = wd[0];
      if (wd[1]) q.delete();
    end
    if (rd && rid == BASE) m_ovf = ovf_set;
    else m_ovf = m_ovf | ovf_set;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, compare comb read and tx against the model, clock, update model.
  task automatic cycle(logic r, logic w, logic [7:0] wid, logic [7:0] wd,
                       logic rd, logic [7:0] rid);
    rst = r; io_wr_stb = w; io_output_id = wid; io_output = wd;
    io_rd_stb = rd; io_input_id = rid;
    #1;
    check("model_rdmux", io_input, model_read(rid));
    check("model_tx", tx, m_tx);
    @(posedge clk);
    model_edge(r, w, wid, wd, rd, rid);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) cycle(0, 0, 8'h00, 8'h00, 0, BASE);
  endtask

  task automatic wr(logic [7:0] id, logic [7:0] d);
    cycle(0, 1, id, d, 0, BASE);
  endtask

  task automatic do_reset();
    cycle(1, 0, 8'h00, 8'h00, 0, BASE);
    cycle(1, 0, 8'h00, 8'h00, 0, BASE);
  endtask

  typedef struct {
    logic       w;
    logic [7:0] wid;
    logic [7:0] wd;
    logic       rd;
    logic [7:0] rid;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int busy_cycles, changes, last, cnt;
    logic [7:0] a5;
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h12, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h0F, 8'h00};
    vecs[3]  = '{1'b1, 8'h11, 8'h01, 1'b0, 8'h11, 8'h01};
    vecs[4]  = '{1'b1, 8'h11, 8'h00, 1'b0, 8'h11, 8'h00};
    vecs[5]  = '{1'b1, 8'h10, 8'h33, 1'b0, 8'h10, 8'h10};
    vecs[6]  = '{1'b1, 8'h10, 8'h44, 1'b0, 8'h10, 8'h20};
    vecs[7]  = '{1'b1, 8'h12, 8'h55, 1'b0, 8'h10, 8'h20};
    vecs[8]  = '{1'b1, 8'h11, 8'h02, 1'b0, 8'h10, 8'h01};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h01};
    vecs[10] = '{1'b1, 8'h10, 8'h77, 1'b0, 8'h55, 8'h00};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h10, 8'h10};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Reset state held for 100 cycles.
    check("reset_status", io_input, 8'h01);
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (tx !== 1'b1 || io_input !== 8'h01) check("reset_hold", {io_input, 7'b0, tx}, 16'h0101);
    end
    check("reset_tx", tx, 1'b1);

    // Register-level vectors.
    for (int i = 0; i < 12; i++) begin
      cycle(0, vecs[i].w, vecs[i].wid, vecs[i].wd, vecs[i].rd, vecs[i].rid);
      check($sformatf("vec%0d", i), io_input, vecs[i].exp);
    end

    // Single 0xA5 frame: latency and exact waveform.
    do_reset();
    wr(CTRL, 8'h01);
    wr(BASE, 8'hA5);
    check("lat_n", tx, 1'b1);
    idle(1);
    check("lat_n1", tx, 1'b1);
    a5 = 8'hA5;
    for (int k = 0; k < 160; k++) begin
      idle(1);
      check($sformatf("a5_k%0d", k), tx, (k < C) ? 1'b0 : (k < 9 * C) ? a5[(k - C) / C] : 1'b1);
      if (k == 50) check("a5_busy_status", io_input, 8'h05);
    end
    idle(1);
    check("a5_done_status", io_input, 8'h01);
    check("a5_done_tx", tx, 1'b1);

    // Three queued bytes go out as contiguous frames.
    do_reset();
    wr(BASE, 8'h11); wr(BASE, 8'h22); wr(BASE, 8'h33);
    check("three_status", io_input, 8'h30);
    wr(CTRL, 8'h01);
    busy_cycles = 0; changes = 0; last = 3;
    for (int i = 0; i < 600; i++) begin
      idle(1);
      cnt = int'(io_input[7:4]);
      if (io_input[2]) busy_cycles++;
      if (cnt != last) begin
        check("three_count_step", cnt, last - 1);
        last = cnt;
        changes++;
      end
    end
    check("three_changes", changes, 3);
    check("three_busy_cycles", busy_cycles, 480);

    // Overflow with transmitter disabled.
    do_reset();
    for (int i = 0; i < 9; i++) wr(BASE, 8'(i + 1));
    check("ovf_status", io_input, 8'h8A);
    cycle(0, 0, 8'h00, 8'h00, 1, BASE);
    check("ovf_cleared", io_input, 8'h82);

    // Flush during an active frame.
    do_reset();
    wr(CTRL, 8'h01);
    wr(BASE, 8'h3C);
    wr(BASE, 8'h5A);
    idle(40);
    check("flush_pre", io_input, 8'h14);
    wr(CTRL, 8'h03);
    check("flush_during", io_input, 8'h05);
    for (int i = 0; i < 400 && io_input[2]; i++) idle(1);
    check("flush_finished", io_input, 8'h01);
    idle(50);
    check("flush_no_second", io_input, 8'h01);
    check("flush_tx_idle", tx, 1'b1);

    // Reset in the middle of the data bits.
    do_reset();
    wr(CTRL, 8'h01);
    wr(BASE, 8'h00);
    idle(60);
    check("mid_data_low", tx, 1'b0);
    cycle(1, 0, 8'h00, 8'h00, 0, BASE);
    check("rst_tx", tx, 1'b1);
    check("rst_status", io_input, 8'h01);
    wr(CTRL, 8'h01);
    wr(BASE, 8'h96);
    idle(175);
    check("post_rst_frame_done", io_input, 8'h01);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic r, w, rd;
      logic [7:0] wid, wd, rid;
      r  = ($urandom_range(0, 1999) == 0);
      w  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0, 1:    wid = BASE;
        2:       wid = CTRL;
        default: wid = 8'($urandom);
      endcase
      wd = 8'($urandom);
      if (wid == CTRL) wd = {6'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0};
      rd = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0, 1:    rid = BASE;
        2:       rid = CTRL;
        default: rid = 8'($urandom);
      endcase
      cycle(r, w, wid, wd, rd, rid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
